// File: rtl/trans_validator_pipe_if.sv
// Handshake/bus bundle for trans_validator_pipe: record in, capture ack, result pulses, table count.
// Latency: none (wires only).
// Backpressure: valid_i is held by the source until ack_o; ack_o only fires while the validator is idle.
// Ports: data_i/valid_i (source -> validator); ack_o, busy_o, data_o, valid_o,
//        reject_o, reason_o, count_o (validator -> sink).
interface trans_validator_pipe_if #(
    parameter int DATA_W = 128,
    parameter int CNT_W  = 15
);
    logic [DATA_W-1:0] data_i;
    logic              valid_i;
    logic              ack_o;
    logic              busy_o;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              reject_o;
    logic [1:0]        reason_o;
    logic [CNT_W-1:0]  count_o;

    modport master (
        output data_i, valid_i,
        input  ack_o, busy_o, data_o, valid_o, reject_o, reason_o, count_o
    );

    modport slave (
        input  data_i, valid_i,
        output ack_o, busy_o, data_o, valid_o, reject_o, reason_o, count_o
    );
endinterface

// File: rtl/trans_validator_pipe.sv
// Transfer validator: finds/allocates sender+receiver in an on-chip {id,balance} table, checks, commits or rejects.
// Latency: ack 1 cycle after capture; verdict after scan (<= count+2 cycles) + ALLOC + CHECK; up to 2 write cycles follow.
// Backpressure: one record in flight; valid_i is ignored (no ack) until the FSM is back in IDLE.
// Ports: clk, rst (sync, active high); bus = trans_validator_pipe_if.slave carrying record, ack/busy and result pulses.
module trans_validator_pipe #(
    parameter int ID_W      = 48,
    parameter int AMT_W     = 22,
    parameter int BAL_W     = 24,
    parameter int LOW_W     = 10,
    parameter int BLOCK_BIT = 9,
    parameter int DEPTH     = 16384,
    parameter int INIT_BAL  = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    trans_validator_pipe_if.slave bus
);
    localparam int DATA_W = 2*ID_W + AMT_W + LOW_W;
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam int EW     = ID_W + BAL_W;

    typedef enum logic [2:0] {IDLE, SCAN, SCAN_D, ALLOC, CHECK, WR_S, WR_R} state_t;

    // Account table: one write port, one registered read port.
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] rd_data_q;
    logic [AW-1:0] rd_addr;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [EW-1:0] ram_wdata;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ack_q, ack_d, busy_q, busy_d, valid_q, valid_d, reject_q, reject_d;
    logic [1:0]        reason_q, reason_d;
    logic [CW-1:0]     count_q, count_d, wcount_q, wcount_d, addr_q, addr_d, new_cnt_q, new_cnt_d;
    logic              s_found_q, s_found_d, r_found_q, r_found_d, full_q, full_d;
    logic [AW-1:0]     s_ptr_q, s_ptr_d, r_ptr_q, r_ptr_d;
    logic [BAL_W-1:0]  s_bal_q, s_bal_d, r_bal_q, r_bal_d;

    logic [ID_W-1:0]   sender, receiver, rd_id;
    logic [AMT_W-1:0]  amount;
    logic [BAL_W-1:0]  amt_ext, rd_bal;
    logic [BAL_W:0]    r_sum;
    logic [CW-1:0]     idx;
    logic [CW:0]       nc;
    logic              self_xfer, s_hit, r_hit;

    assign sender    = data_q[DATA_W-1 -: ID_W];
    assign receiver  = data_q[DATA_W-ID_W-1 -: ID_W];
    assign amount    = data_q[LOW_W +: AMT_W];
    assign amt_ext   = BAL_W'(amount);
    assign rd_id     = rd_data_q[EW-1 -: ID_W];
    assign rd_bal    = rd_data_q[BAL_W-1:0];
    assign self_xfer = (sender == receiver);
    // Carry out of the widened sum flags a receiver balance that would wrap.
    assign r_sum     = {1'b0, r_bal_q} + {1'b0, amt_ext};

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        ack_d     = 1'b0;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        reject_d  = 1'b0;
        reason_d  = reason_q;
        count_d   = count_q;
        wcount_d  = wcount_q;
        addr_d    = addr_q;
        new_cnt_d = new_cnt_q;
        s_found_d = s_found_q;
        r_found_d = r_found_q;
        full_d    = full_q;
        s_ptr_d   = s_ptr_q;
        r_ptr_d   = r_ptr_q;
        s_bal_d   = s_bal_q;
        r_bal_d   = r_bal_q;
        rd_addr   = addr_q[AW-1:0];
        ram_we    = 1'b0;
        ram_waddr = s_ptr_q;
        ram_wdata = {sender, s_bal_q};
        idx       = addr_q - CW'(1);
        nc        = {1'b0, wcount_q};
        s_hit     = 1'b0;
        r_hit     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.valid_i) begin
                    data_d    = bus.data_i;
                    ack_d     = 1'b1;
                    busy_d    = 1'b1;
                    // Block start: the table is logically emptied for this record only.
                    wcount_d  = bus.data_i[BLOCK_BIT] ? '0 : count_q;
                    addr_d    = '0;
                    s_found_d = 1'b0;
                    r_found_d = 1'b0;
                    full_d    = 1'b0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                rd_addr = '0;
                addr_d  = CW'(1);
                state_d = SCAN_D;
            end
            SCAN_D: begin
                // rd_data_q holds entry addr_q-1; addr_q is issued as the next read.
                if (idx >= wcount_q) begin
                    state_d = ALLOC;
                end else begin
                    s_hit = (rd_id == sender);
                    r_hit = (rd_id == receiver);
                    if (s_hit) begin
                        s_found_d = 1'b1;
                        s_ptr_d   = idx[AW-1:0];
                        s_bal_d   = rd_bal;
                    end
                    if (r_hit) begin
                        r_found_d = 1'b1;
                        r_ptr_d   = idx[AW-1:0];
                        r_bal_d   = rd_bal;
                    end
                    if ((s_found_q || s_hit) && (r_found_q || r_hit)) begin
                        state_d = ALLOC;
                    end else begin
                        addr_d = addr_q + CW'(1);
                    end
                end
            end
            ALLOC: begin
                if (!s_found_q) begin
                    s_ptr_d = nc[AW-1:0];
                    s_bal_d = BAL_W'(INIT_BAL);
                    nc      = nc + (CW+1)'(1);
                end
                if (!r_found_q) begin
                    // A self-transfer shares the single sender entry.
                    if (self_xfer) begin
                        r_ptr_d = s_ptr_d;
                        r_bal_d = s_bal_d;
                    end else begin
                        r_ptr_d = nc[AW-1:0];
                        r_bal_d = BAL_W'(INIT_BAL);
                        nc      = nc + (CW+1)'(1);
                    end
                end
                full_d    = (nc > (CW+1)'(DEPTH));
                new_cnt_d = nc[CW-1:0];
                state_d   = CHECK;
            end
            CHECK: begin
                if (full_q || (s_bal_q < amt_ext) || (!self_xfer && r_sum[BAL_W])) begin
                    // Tentative allocations are dropped simply by not committing new_cnt.
                    reject_d = 1'b1;
                    reason_d = full_q ? 2'd2 : (s_bal_q < amt_ext) ? 2'd1 : 2'd3;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    valid_d  = 1'b1;
                    reason_d = 2'd0;
                    count_d  = new_cnt_q;
                    if (!self_xfer) begin
                        s_bal_d = s_bal_q - amt_ext;
                        r_bal_d = r_sum[BAL_W-1:0];
                    end
                    state_d  = WR_S;
                end
            end
            WR_S: begin
                ram_we    = 1'b1;
                ram_waddr = s_ptr_q;
                ram_wdata = {sender, s_bal_q};
                if (self_xfer) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = WR_R;
                end
            end
            WR_R: begin
                ram_we    = 1'b1;
                ram_waddr = r_ptr_q;
                ram_wdata = {receiver, r_bal_q};
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        // A reset edge must not land a write from an interrupted record.
        if (rst) ram_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        rd_data_q <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            reject_q  <= 1'b0;
            reason_q  <= 2'd0;
            count_q   <= '0;
            wcount_q  <= '0;
            addr_q    <= '0;
            new_cnt_q <= '0;
            s_found_q <= 1'b0;
            r_found_q <= 1'b0;
            full_q    <= 1'b0;
            s_ptr_q   <= '0;
            r_ptr_q   <= '0;
            s_bal_q   <= '0;
            r_bal_q   <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            reject_q  <= reject_d;
            reason_q  <= reason_d;
            count_q   <= count_d;
            wcount_q  <= wcount_d;
            addr_q    <= addr_d;
            new_cnt_q <= new_cnt_d;
            s_found_q <= s_found_d;
            r_found_q <= r_found_d;
            full_q    <= full_d;
            s_ptr_q   <= s_ptr_d;
            r_ptr_q   <= r_ptr_d;
            s_bal_q   <= s_bal_d;
            r_bal_q   <= r_bal_d;
        end
    end

    assign bus.ack_o    = ack_q;
    assign bus.busy_o   = busy_q;
    assign bus.data_o   = data_q;
    assign bus.valid_o  = valid_q;
    assign bus.reject_o = reject_q;
    assign bus.reason_o = reason_q;
    assign bus.count_o  = count_q;
endmodule

// File: doc/trans_validator_pipe.md
Name: trans_validator_pipe

Overview:
- Parametrised next generation of the transaction validator. Accepts packed transfer records (sender ID, receiver ID, amount, low flag bits) and keeps an on-chip account table of {id, balance}.
- Linear search finds or allocates both accounts, checks funds and receiver overflow, and either commits or rejects the transfer with a reason code.
- Adds over the previous generation: synchronous reset, configurable widths/depth/initial balance, table-full and overflow detection, explicit reject output, and rollback of allocations on reject.

Parameters:
- ID_W, 48: account ID width.
- AMT_W, 22: amount field width.
- BAL_W, 24: balance width; must be >= AMT_W.
- LOW_W, 10: low passthrough field width.
- BLOCK_BIT, 9: bit index within the low field marking block start.
- DEPTH, 16384: account table entries (power of two).
- INIT_BAL, 100: balance assigned to a newly seen account.
- Derived: DATA_W = 2*ID_W+AMT_W+LOW_W (128 by default); AW = $clog2(DEPTH).
- Field layout: data_i = {sender[ID_W], receiver[ID_W], amount[AMT_W], low[LOW_W]}.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- data_i  in  DATA_W  transfer record
- valid_i  in  1  record present; held by source until ack_o
- ack_o  out  1  one-cycle pulse: record captured
- busy_o  out  1  high from capture until return to IDLE
- data_o  out  DATA_W  captured record, stable from ack_o until next capture
- valid_o  out  1  one-cycle pulse: transfer accepted and committed
- reject_o  out  1  one-cycle pulse: transfer rejected
- reason_o  out  2  qualifies valid_o/reject_o: 0 OK, 1 FUNDS, 2 FULL, 3 OVERFLOW
- count_o  out  AW+1  accounts currently in table

Behaviour:
- Reset (rst high at a clk edge): state IDLE; count, ack_o, busy_o, valid_o, reject_o, reason_o and data_o go to 0. RAM write enable is forced low in the same cycle, so a reset mid-operation commits nothing further. RAM contents are not cleared; count gates all lookups.
- RAM: one write port, one read port, 1-cycle read latency, internal.
- States: IDLE, SCAN, SCAN_D, ALLOC, CHECK, WR_S, WR_R.
- IDLE:
  - On valid_i: capture data_i into data_o, pulse ack_o next cycle, set busy_o, go to SCAN.
  - If low[BLOCK_BIT]=1, the working count is 0 for this record; the table is logically emptied.
  - valid_i is ignored whenever the state is not IDLE.
- SCAN: issue read address 0, go to SCAN_D.
- SCAN_D: each cycle compares the returned entry ID against sender and receiver and latches pointer and balance on a match, while issuing the next address. Exit to ALLOC when addresses reach working count, or when both IDs are found. Scan cost is at most count+2 cycles.
- ALLOC:
  - Each missing ID gets the next free index with balance INIT_BAL.
  - Sender==receiver counts as one account.
  - If the new count would exceed DEPTH: reason FULL and go to CHECK.
- CHECK:
  - FULL takes priority over the other checks.
  - sender_bal < amount: reason FUNDS.
  - Otherwise, if sender != receiver and receiver_bal + amount > 2^BAL_W-1: reason OVERFLOW.
  - Otherwise reason OK.
  - On OK: pulse valid_o, commit count, go to WR_S.
  - On any reject: pulse reject_o, discard tentative allocations (count unchanged), go to IDLE.
  - Zero amount is OK.
- Commit arithmetic: sender_bal -= amount; receiver_bal += amount. Arithmetic is BAL_W wide, amount zero-extended. Self-transfer leaves the balance unchanged.
- WR_S: write {sender, sender_bal}. Then go to WR_R, or to IDLE on a self-transfer.
- WR_R: write {receiver, receiver_bal}, go to IDLE. busy_o drops on entry to IDLE.
- Ordering guarantees:
  - Exactly one of valid_o/reject_o pulses per ack_o, never both.
  - A new capture is only possible after all writes of the prior record are complete, so reads never see stale data.

Test Plan:
- Reset then transfer A->B, amount 30, block bit 1 -> ack_o; valid_o with reason 0; count_o=2. Then B->A amount 130 -> valid_o; A balance 200, B balance 0.
- A->B amount 101 on an empty table -> reject_o with reason 1 (FUNDS); count_o stays 0. A following A->C amount 100 -> valid_o; count_o=2.
- DEPTH=4, fill with 4 accounts, then transfer between two new IDs -> reject_o with reason 2 (FULL); count_o=4; existing balances unchanged.
- BAL_W=8, INIT_BAL=200: A->B 60 -> valid_o (B=260 would exceed 255) -> instead reject_o with reason 3 (OVERFLOW); A->B 55 -> valid_o, B=255.
- Self-transfer A->A amount 50 -> valid_o; count_o increments by 1; balance 100. Repeat with block bit 1 -> count_o=1.
- Assert rst during SCAN_D of a valid transfer -> no valid_o/reject_o pulse, no RAM write; count_o=0; next record is accepted normally. Also hold valid_i high throughout busy_o -> exactly one ack_o per record.
